mem_arbiter2: RTL and testbench

Two-master round-robin arbiter for the PicoRV32 native memory interface. It shares one downstream memory/MMIO port, such as the testbench RAM plus the 0x1000_0000 console, between two native-interface requesters: CPU and DMA, or two CPU cores. The arbiter locks the downstream port for one whole transaction and forwards the response to the owning master. A per-transaction timeout keeps a missing downstream ready from hanging the system.

---
 rtl/mem_arbiter2_if.sv | 20 ++
 rtl/mem_arbiter2.sv | 105 ++++++++++
 tb/tb_mem_arbiter2.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter2_if.sv
// rtl/mem_arbiter2_if.sv - PicoRV32 native memory interface bundle
interface mem_arbiter2_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - two-master round-robin arbiter with per-transaction timeout
module mem_arbiter2 #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter2_if.slave  m0,
  mem_arbiter2_if.slave  m1,
  mem_arbiter2_if.master mem,
  output logic           err,
  output logic           err_master
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic        TIMEOUT_EN  = (TIMEOUT != 0);

  state_t      state;
  logic        grant;
  logic        prio;
  logic [15:0] wait_cnt;

  logic        busy;
  logic        gnt_valid;
  logic        timeout_hit;
  logic        done;
  logic        forced;
  logic        req_valid;
  logic [31:0] rdata_out;

  always_comb begin
    busy        = (state == BUSY);
    gnt_valid   = grant ? m1.valid : m0.valid;
    timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT);
    done        = busy && gnt_valid && (mem.ready || timeout_hit);
    // mem_ready wins over the timeout, so a forced completion needs ready low
    forced      = done && !mem.ready;
    req_valid   = busy && gnt_valid;
    rdata_out   = forced ? 32'h0000_0000 : mem.rdata;
  end

  always_comb begin
    mem.valid = req_valid;
    mem.instr = 1'b0;
    mem.addr  = 32'h0000_0000;
    mem.wdata = 32'h0000_0000;
    mem.wstrb = 4'h0;
    if (busy) begin
      mem.instr = grant ? m1.instr : m0.instr;
      mem.addr  = grant ? m1.addr  : m0.addr;
      mem.wdata = grant ? m1.wdata : m0.wdata;
      mem.wstrb = grant ? m1.wstrb : m0.wstrb;
    end
    if (!req_valid) begin
      mem.wstrb = 4'h0;
    end
  end

  always_comb begin
    m0.ready = done && !grant;
    m1.ready = done && grant;
    m0.rdata = (done && !grant) ? rdata_out : 32'h0000_0000;
    m1.rdata = (done && grant)  ? rdata_out : 32'h0000_0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      prio       <= 1'b0;
      wait_cnt   <= 16'h0000;
      err        <= 1'b0;
      err_master <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0.valid || m1.valid) begin
            grant    <= (m0.valid && m1.valid) ? prio : m1.valid;
            wait_cnt <= 16'h0000;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!gnt_valid) begin
            // master abandoned its request: release without ready or fairness update
            state <= IDLE;
          end else if (done) begin
            state <= IDLE;
            prio  <= ~grant;
            if (forced) begin
              err        <= 1'b1;
              err_master <= grant;
            end
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'h0001;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - table-driven self-checking bench for mem_arbiter2
module tb_mem_arbiter2;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] A1 = 32'h1000_0000;
  localparam logic [31:0] D1 = 32'h1234_5678;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic clk;
  logic reset;
  logic err;
  logic err_master;

  mem_arbiter2_if m0_if();
  mem_arbiter2_if m1_if();
  mem_arbiter2_if mem_if();

  mem_arbiter2 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem       (mem_if),
    .err       (err),
    .err_master(err_master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: 0 = m0 fields on the bus, 1 = m1 fields, 2 = all zero, 3 = bus fields not checked
  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic [3:0]  s1;
    logic        mrdy;
    logic        e_mv;
    logic [1:0]  e_sel;
    logic        e_r0;
    logic        e_r1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic        e_err;
    logic        e_errm;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, v0, v1, input logic [3:0] s1, input logic mrdy,
                              input logic mv, input logic [1:0] sel, input logic r0, r1,
                              input logic [31:0] rd0, rd1, input logic e, em);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.s1 = s1; v.mrdy = mrdy;
    v.e_mv = mv; v.e_sel = sel; v.e_r0 = r0; v.e_r1 = r1;
    v.e_rd0 = rd0; v.e_rd1 = rd1; v.e_err = e; v.e_errm = em;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): actual %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, v0, v1, input logic [3:0] s1, input logic mrdy);
    reset       = rst;
    m0_if.valid = v0;
    m1_if.valid = v1;
    m1_if.wstrb = s1;
    mem_if.ready = mrdy;
  endtask

  task automatic run_row(input vec_t v, input int row);
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ei;
    logic [3:0]  es;
    drive(v.rst, v.v0, v.v1, v.s1, v.mrdy);
    #2;
    ea = (v.e_sel == 2'd0) ? A0 : (v.e_sel == 2'd1) ? A1 : 32'h0;
    ed = (v.e_sel == 2'd0) ? D0 : (v.e_sel == 2'd1) ? D1 : 32'h0;
    ei = (v.e_sel == 2'd0);
    es = (v.e_mv && v.e_sel == 2'd1) ? v.s1 : 4'h0;
    check("mem_valid", row, 32'(mem_if.valid), 32'(v.e_mv));
    check("mem_wstrb", row, 32'(mem_if.wstrb), 32'(es));
    if (v.e_sel != 2'd3) begin
      check("mem_addr",  row, mem_if.addr,  ea);
      check("mem_wdata", row, mem_if.wdata, ed);
      check("mem_instr", row, 32'(mem_if.instr), 32'(ei));
    end
    check("m0_ready", row, 32'(m0_if.ready), 32'(v.e_r0));
    check("m1_ready", row, 32'(m1_if.ready), 32'(v.e_r1));
    check("m0_rdata", row, m0_if.rdata, v.e_rd0);
    check("m1_rdata", row, m1_if.rdata, v.e_rd1);
    check("err", row, 32'(err), 32'(v.e_err));
    if (v.e_err) check("err_master", row, 32'(err_master), 32'(v.e_errm));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[$];
    m0_if.instr = 1'b1; m0_if.addr = A0; m0_if.wdata = D0; m0_if.wstrb = 4'h0;
    m1_if.instr = 1'b0; m1_if.addr = A1; m1_if.wdata = D1;
    mem_if.rdata = RD;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    //            rst v0 v1 s1    rdy  mv sel r0 r1 rd0 rd1 err errm
    tbl.push_back(mk(1, 0, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0)); // reset state
    tbl.push_back(mk(0, 1, 0, 4'h0, 1,  0, 2, 0, 0, 0,  0,  0, 0)); // single read: idle
    tbl.push_back(mk(0, 1, 0, 4'h0, 1,  1, 0, 1, 0, RD, 0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hF, 1,  0, 2, 0, 0, 0,  0,  0, 0)); // contention after reset
    tbl.push_back(mk(0, 1, 1, 4'hF, 1,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 4'hF, 1,  1, 0, 1, 0, RD, 0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hF, 1,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hF, 1,  1, 1, 0, 1, 0,  RD, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0)); // wait states
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  1, 0, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  1, 0, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  1, 0, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 1,  1, 0, 1, 0, RD, 0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0)); // timeout, m1 read
    tbl.push_back(mk(0, 0, 1, 4'h0, 0,  1, 1, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, 0,  1, 1, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, 0,  1, 1, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, 0,  1, 1, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h0, 0,  1, 1, 0, 1, 0,  0,  0, 0)); // forced, BUSY cycle 5
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  1, 1)); // err pulse
    tbl.push_back(mk(0, 1, 0, 4'h0, 1,  1, 0, 1, 0, RD, 0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0)); // reset mid-BUSY
    tbl.push_back(mk(0, 1, 0, 4'h0, 0,  1, 0, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 4'h0, 0,  1, 0, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 4'h0, 1,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0,  0, 3, 0, 0, 0,  0,  0, 0)); // valid dropped mid-BUSY
    tbl.push_back(mk(0, 0, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 4'hF, 1,  0, 2, 0, 0, 0,  0,  0, 0)); // prio still favours m0
    tbl.push_back(mk(0, 1, 1, 4'hF, 1,  1, 0, 1, 0, RD, 0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0,  0, 2, 0, 0, 0,  0,  0, 0));

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

    // round-robin: both masters requesting for 12 cycles after reset
    drive(1'b1, 1'b0, 1'b0, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b1, 4'hF, 1'b1);
    for (int c = 0; c < 12; c++) begin
      #2;
      if (m0_if.ready) order.push_back(0);
      if (m1_if.ready) begin
        order.push_back(1);
        check("rr_m1_wstrb", c, 32'(mem_if.wstrb), 32'h0000_000F);
      end
      @(posedge clk);
      #1;
    end
    check("rr_count", 100, 32'(order.size()), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++) check("rr_order", 100 + i, 32'(order[i]), 32'(i % 2));

    // mem_ready arriving in the timeout cycle completes normally without err
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      #2;
      check("tie_wait_ready", 200 + c, 32'(m1_if.ready), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_if.ready = 1'b1;
    #2;
    check("tie_ready", 204, 32'(m1_if.ready), 32'd1);
    check("tie_rdata", 204, m1_if.rdata, RD);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    #2;
    check("tie_err", 205, 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
